// File: rtl/mips_cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache:
// FSM encoding, address-split widths and the byte-lane merge.
package mips_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } cache_state_e;

    localparam int DEF_NUM_LINES      = 16;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_ADDR_W         = 32;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                width = i + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

    // Byte offset plus word-in-line offset.
    function automatic int offset_bits(input int words_per_line);
        return clog2(words_per_line) + 2;
    endfunction

    function automatic int index_bits(input int num_lines);
        return clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int addr_w, input int num_lines, input int words_per_line);
        return addr_w - offset_bits(words_per_line) - index_bits(num_lines);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  byteen);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (byteen[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data arrays for the data cache: one combinational read port and
// one byte-enabled write port; only the valid bits are reset.
module cache_line_store
    import mips_cache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 24,
    parameter int IDX_W          = 4,
    parameter int WORD_W         = 2
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [WORD_W-1:0] rd_word_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [31:0]       rd_data_o,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [WORD_W-1:0] wr_word_i,
    input  logic              data_we_i,
    input  logic [31:0]       wr_data_i,
    input  logic [3:0]        wr_be_i,
    input  logic              tag_we_i,
    input  logic [TAG_W-1:0]  wr_tag_i
);
    localparam int WPL_BITS = clog2(WORDS_PER_LINE);
    localparam int FLAT_W   = IDX_W + WPL_BITS;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [2**FLAT_W];
    logic [FLAT_W-1:0]    rd_flat_s;
    logic [FLAT_W-1:0]    wr_flat_s;

    if (WPL_BITS > 0) begin : g_flat_multi
        assign rd_flat_s = {rd_idx_i, rd_word_i[WPL_BITS-1:0]};
        assign wr_flat_s = {wr_idx_i, wr_word_i[WPL_BITS-1:0]};
    end else begin : g_flat_single
        logic unused_word_s;
        assign unused_word_s = ^{rd_word_i, wr_word_i};
        assign rd_flat_s     = rd_idx_i;
        assign wr_flat_s     = wr_idx_i;
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_flat_s];

    // Valid bits: cleared asynchronously, set when a refill completes.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end else begin
            valid_q <= valid_q;
        end
    end

    // Tag and data arrays carry no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (tag_we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
        if (data_we_i) begin
            data_q[wr_flat_s] <= merge_bytes(data_q[wr_flat_s], wr_data_i, wr_be_i);
        end
    end

endmodule

// File: rtl/dcache_wt_checker.sv
// Protocol properties for the cache's core and memory sides.
module dcache_wt_checker #(
    parameter int ADDR_W = 32
) (
    input logic              clk,
    input logic              reset_n,
    input logic              re,
    input logic              we,
    input logic [ADDR_W-1:0] a,
    input logic              ack,
    input logic              mem_req,
    input logic              mem_ack,
    input logic [ADDR_W-1:0] mem_adr,
    input logic [31:0]       mem_wdata
);
    // The core must hold its address while a request is outstanding.
    a_core_addr_stable: assert property (@(posedge clk) disable iff (!reset_n)
        ((re || we) && !ack) |=> (a == $past(a)))
        else $error("core address changed while request pending");

    a_mem_beat_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (mem_req && !mem_ack) |=> (mem_req && mem_adr == $past(mem_adr) && mem_wdata == $past(mem_wdata)))
        else $error("memory beat not held until mem_ack");

    a_ack_needs_req: assert property (@(posedge clk) disable iff (!reset_n)
        ack |-> (re || we))
        else $error("ack without a core request");

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of a
// one-word-per-beat memory; the core is stalled until ack.
module dcache_wt
    import mips_cache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] a,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteen,
    output logic [31:0]       readdata,
    output logic              ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byteen,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);
    localparam int WORD_BITS = clog2(WORDS_PER_LINE);
    localparam int IDX_BITS  = index_bits(NUM_LINES);
    localparam int OFF_BITS  = offset_bits(WORDS_PER_LINE);
    localparam int TAG_W     = tag_bits(ADDR_W, NUM_LINES, WORDS_PER_LINE);
    localparam int CNT_W     = (WORD_BITS > 0) ? WORD_BITS : 1;

    cache_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [IDX_BITS-1:0] idx_s;
    logic [TAG_W-1:0]    tag_s;
    logic [CNT_W-1:0]    word_s;
    logic                last_beat_s;
    logic [ADDR_W-1:0]   refill_adr_s;
    logic [ADDR_W-1:0]   write_adr_s;
    logic                hit_s;
    logic                unused_addr_s;

    logic                rd_valid_s;
    logic [TAG_W-1:0]    rd_tag_s;
    logic [31:0]         rd_data_s;
    logic                st_data_we_s;
    logic                st_tag_we_s;
    logic [CNT_W-1:0]    st_word_s;
    logic [31:0]         st_data_s;
    logic [3:0]          st_be_s;

    assign idx_s         = a[OFF_BITS +: IDX_BITS];
    assign tag_s         = a[ADDR_W-1 -: TAG_W];
    assign write_adr_s   = {a[ADDR_W-1:2], 2'b00};
    assign unused_addr_s = ^a[1:0];

    // Last beat is detected from an all-ones counter, never from overflow.
    if (WORD_BITS > 0) begin : g_multi_word
        assign word_s       = a[2 +: WORD_BITS];
        assign last_beat_s  = &cnt_q;
        assign refill_adr_s = {a[ADDR_W-1:OFF_BITS], cnt_q, 2'b00};
    end else begin : g_single_word
        assign word_s       = 1'b0;
        assign last_beat_s  = 1'b1;
        assign refill_adr_s = {a[ADDR_W-1:2], 2'b00};
    end

    assign hit_s = rd_valid_s && (rd_tag_s == tag_s);

    cache_line_store #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W),
        .IDX_W          (IDX_BITS),
        .WORD_W         (CNT_W)
    ) u_store (
        .clk        (clk),
        .rst_n_i    (reset_n),
        .rd_idx_i   (idx_s),
        .rd_word_i  (word_s),
        .rd_valid_o (rd_valid_s),
        .rd_tag_o   (rd_tag_s),
        .rd_data_o  (rd_data_s),
        .wr_idx_i   (idx_s),
        .wr_word_i  (st_word_s),
        .data_we_i  (st_data_we_s),
        .wr_data_i  (st_data_s),
        .wr_be_i    (st_be_s),
        .tag_we_i   (st_tag_we_s),
        .wr_tag_i   (tag_s)
    );

    // FSM state and refill beat counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, core handshake, memory beat drive and array writes.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ack          = 1'b0;
        readdata     = 32'h0000_0000;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_adr      = '0;
        mem_wdata    = 32'h0000_0000;
        mem_byteen   = 4'h0;
        st_data_we_s = 1'b0;
        st_tag_we_s  = 1'b0;
        st_word_s    = word_s;
        st_data_s    = writedata;
        st_be_s      = byteen;
        case (state_q)
            ST_IDLE: begin
                // A store wins over a simultaneous load; misses leave the array alone.
                if (we) begin
                    st_data_we_s = hit_s;
                    state_d      = ST_WRITE;
                end else if (re) begin
                    if (hit_s) begin
                        ack      = 1'b1;
                        readdata = rd_data_s;
                    end else begin
                        state_d = ST_REFILL;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REFILL: begin
                mem_req    = 1'b1;
                mem_adr    = refill_adr_s;
                mem_byteen = 4'hF;
                st_word_s  = cnt_q;
                st_data_s  = mem_rdata;
                st_be_s    = 4'hF;
                if (mem_ack) begin
                    st_data_we_s = 1'b1;
                    if (last_beat_s) begin
                        st_tag_we_s = 1'b1;
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WRITE: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                mem_adr    = write_adr_s;
                mem_wdata  = writedata;
                mem_byteen = byteen;
                if (mem_ack) begin
                    ack     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt against a word=address memory model.
module tb_dcache_wt;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        re, we;
    logic [31:0] a, writedata, readdata;
    logic [3:0]  byteen;
    logic        ack;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_adr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byteen;

    always #5 clk = ~clk;

    dcache_wt #(.NUM_LINES(16), .WORDS_PER_LINE(4), .ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .re(re), .we(we), .a(a),
        .writedata(writedata), .byteen(byteen), .readdata(readdata), .ack(ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen), .mem_rdata(mem_rdata), .mem_ack(mem_ack));

    dcache_wt_checker #(.ADDR_W(32)) chk (
        .clk(clk), .reset_n(reset_n), .re(re), .we(we), .a(a), .ack(ack),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_adr(mem_adr), .mem_wdata(mem_wdata));

    // Memory model: word at address X holds X until written through.
    logic [31:0] mem [0:511];
    bit          stall_mode = 1'b0;
    int          ph = 0;
    assign mem_ack   = mem_req && (!stall_mode || ph == 2);
    assign mem_rdata = mem[mem_adr[10:2]];

    int          beat_cnt = 0, wr_beats = 0, hold_err = 0;
    logic [31:0] rd_adrs [$];
    logic [31:0] last_wadr, last_wdata;
    logic [3:0]  last_be;
    logic        prev_pending = 1'b0;
    logic [31:0] prev_adr = 32'h0;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] <= 32'(i * 4);
    end

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            beat_cnt++;
            if (mem_we) begin
                wr_beats++;
                last_be = mem_byteen; last_wadr = mem_adr; last_wdata = mem_wdata;
                for (int b = 0; b < 4; b++)
                    if (mem_byteen[b]) mem[mem_adr[10:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                rd_adrs.push_back(mem_adr);
            end
        end
        if (prev_pending && mem_req && mem_adr !== prev_adr) hold_err++;
        prev_pending = mem_req && !mem_ack;
        prev_adr     = mem_adr;
        if (!mem_req || mem_ack) ph <= 0;
        else ph <= ph + 1;
    end

    int          n_checks = 0, n_pass = 0;
    logic [31:0] d;
    int          cyc, s0, b0, w0;

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output int cycles);
        @(negedge clk);
        a = addr; re = 1'b1; we = 1'b0; cycles = 0; data = 32'hDEAD_BEEF;
        #1;
        while (!ack && cycles < 60) begin
            @(negedge clk); #1; cycles++;
        end
        if (ack) data = readdata; else cycles = -1;
        @(posedge clk); #1;
        re = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be,
                            output int cycles);
        @(negedge clk);
        a = addr; we = 1'b1; re = 1'b0; writedata = wd; byteen = be; cycles = 0;
        #1;
        while (!ack && cycles < 60) begin
            @(negedge clk); #1; cycles++;
        end
        if (!ack) cycles = -1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic test_reset();
        re = 1'b0; we = 1'b0; a = 32'h0; writedata = 32'h0; byteen = 4'h0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req_in_reset: got %b expected 0", mem_req); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ack); else n_pass++;
        n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_mem_ctrl: got req=%b we=%b expected 0/0", mem_req, mem_we); else n_pass++;
        n_checks++; if (mem_adr !== 32'h0 || mem_byteen !== 4'h0) $display("FAIL reset_mem_bus: got adr=%h be=%h expected 0/0", mem_adr, mem_byteen); else n_pass++;
    endtask

    task automatic test_refill();
        s0 = rd_adrs.size();
        do_read(32'h40, d, cyc);
        n_checks++; if (cyc !== 5) $display("FAIL refill_latency: got %0d expected 5", cyc); else n_pass++;
        n_checks++; if (d !== 32'h40) $display("FAIL refill_data: got %h expected 00000040", d); else n_pass++;
        n_checks++; if (rd_adrs.size() != s0 + 4) $display("FAIL refill_beats: got %0d expected 4", rd_adrs.size() - s0); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd_adrs.size() <= s0 + k || rd_adrs[s0+k] !== 32'h40 + 32'(4*k))
                $display("FAIL refill_adr%0d: got %h expected %h", k, (rd_adrs.size() > s0 + k) ? rd_adrs[s0+k] : 32'hX, 32'h40 + 32'(4*k));
            else n_pass++;
        end
        b0 = beat_cnt;
        do_read(32'h48, d, cyc);
        n_checks++; if (cyc !== 0 || d !== 32'h48) $display("FAIL hit_read: got cyc=%0d data=%h expected 0/00000048", cyc, d); else n_pass++;
        n_checks++; if (beat_cnt != b0) $display("FAIL hit_no_mem: got %0d beats expected 0", beat_cnt - b0); else n_pass++;
    endtask

    task automatic test_write_hit();
        w0 = wr_beats;
        do_write(32'h44, 32'hAABB_CCDD, 4'b0011, cyc);
        n_checks++; if (cyc !== 1 || wr_beats != w0 + 1) $display("FAIL wr_hit_beat: got cyc=%0d beats=%0d expected 1/1", cyc, wr_beats - w0); else n_pass++;
        n_checks++; if (last_be !== 4'b0011 || last_wadr !== 32'h44 || last_wdata !== 32'hAABB_CCDD)
            $display("FAIL wr_hit_bus: got be=%h adr=%h data=%h expected 3/00000044/aabbccdd", last_be, last_wadr, last_wdata); else n_pass++;
        do_read(32'h44, d, cyc);
        n_checks++; if (cyc !== 0 || d !== 32'h0000_CCDD) $display("FAIL wr_hit_merge: got cyc=%0d data=%h expected 0/0000ccdd", cyc, d); else n_pass++;
    endtask

    task automatic test_write_miss();
        w0 = wr_beats;
        do_write(32'h403, 32'h1122_3344, 4'b1111, cyc);
        n_checks++; if (cyc !== 1 || wr_beats != w0 + 1 || last_wadr !== 32'h400)
            $display("FAIL wr_miss_beat: got cyc=%0d beats=%0d adr=%h expected 1/1/00000400", cyc, wr_beats - w0, last_wadr); else n_pass++;
        do_read(32'h400, d, cyc);
        n_checks++; if (cyc !== 5 || d !== 32'h1122_3344) $display("FAIL no_allocate: got cyc=%0d data=%h expected 5/11223344", cyc, d); else n_pass++;
        do_read(32'h404, d, cyc);
        n_checks++; if (cyc !== 0 || d !== 32'h404) $display("FAIL line_after_miss: got cyc=%0d data=%h expected 0/00000404", cyc, d); else n_pass++;
    endtask

    task automatic test_conflict();
        s0 = rd_adrs.size();
        do_read(32'h440, d, cyc);
        n_checks++; if (cyc !== 5 || d !== 32'h440) $display("FAIL conflict_a: got cyc=%0d data=%h expected 5/00000440", cyc, d); else n_pass++;
        do_read(32'h44, d, cyc);
        n_checks++; if (cyc !== 5 || d !== 32'h0000_CCDD) $display("FAIL conflict_b: got cyc=%0d data=%h expected 5/0000ccdd", cyc, d); else n_pass++;
        do_read(32'h440, d, cyc);
        n_checks++; if (cyc !== 5 || d !== 32'h440) $display("FAIL conflict_c: got cyc=%0d data=%h expected 5/00000440", cyc, d); else n_pass++;
        n_checks++; if (rd_adrs.size() != s0 + 12) $display("FAIL conflict_beats: got %0d expected 12", rd_adrs.size() - s0); else n_pass++;
    endtask

    task automatic test_stall();
        stall_mode = 1'b1;
        s0 = rd_adrs.size();
        hold_err = 0;
        do_read(32'h80, d, cyc);
        n_checks++; if (cyc !== 13 || d !== 32'h80) $display("FAIL stall_refill: got cyc=%0d data=%h expected 13/00000080", cyc, d); else n_pass++;
        n_checks++; if (hold_err != 0) $display("FAIL stall_hold: got %0d changes expected 0", hold_err); else n_pass++;
        n_checks++; if (rd_adrs.size() != s0 + 4 || rd_adrs[s0+3] !== 32'h8C) $display("FAIL stall_beats: got %0d expected 4 ending 0000008c", rd_adrs.size() - s0); else n_pass++;
        do_write(32'h84, 32'h1234_5678, 4'b1100, cyc);
        n_checks++; if (cyc !== 3) $display("FAIL stall_write: got cyc=%0d expected 3", cyc); else n_pass++;
        stall_mode = 1'b0;
        do_read(32'h84, d, cyc);
        n_checks++; if (cyc !== 0 || d !== 32'h1234_0084) $display("FAIL stall_merge: got cyc=%0d data=%h expected 0/12340084", cyc, d); else n_pass++;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        a = 32'h100; re = 1'b1; b0 = beat_cnt;
        for (int i = 0; i < 20 && beat_cnt - b0 < 2; i++) begin
            @(posedge clk); #1;
        end
        n_checks++; if (mem_req !== 1'b1 || beat_cnt - b0 != 2 || mem_adr !== 32'h108)
            $display("FAIL abort_pre: got req=%b beats=%0d adr=%h expected 1/2/00000108", mem_req, beat_cnt - b0, mem_adr); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0 || ack !== 1'b0) $display("FAIL abort_async: got req=%b ack=%b expected 0/0", mem_req, ack); else n_pass++;
        re = 1'b0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        s0 = rd_adrs.size();
        do_read(32'h100, d, cyc);
        n_checks++; if (cyc !== 5 || d !== 32'h100) $display("FAIL abort_refill: got cyc=%0d data=%h expected 5/00000100", cyc, d); else n_pass++;
        n_checks++; if (rd_adrs.size() != s0 + 4 || rd_adrs[s0] !== 32'h100) $display("FAIL abort_beats: got %0d expected 4 from 00000100", rd_adrs.size() - s0); else n_pass++;
        do_read(32'h48, d, cyc);
        n_checks++; if (cyc !== 5 || d !== 32'h48) $display("FAIL abort_invalidate: got cyc=%0d data=%h expected 5/00000048", cyc, d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_refill();
        test_write_hit();
        test_write_miss();
        test_conflict();
        test_stall();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
